// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcode/funct codes,
// ALU operation encodings and the controller state encoding.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Explicit encodings keep the debug state output stable across tools.
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    ADDI_EXEC = 4'd8,
    ADDI_WB   = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11,
    HALT      = 4'd12
  } state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the multi-cycle controller and the datapath.
// master: controller side (decoded fields/flags in, enables/selects out).
// slave : datapath side (the mirror image).
interface multicycle_control_if #(
  parameter int unsigned COUNT_WIDTH = 32
);
  logic [5:0]             opcode;
  logic [5:0]             funct;
  logic                   alu_zout;
  logic                   mem_ready;
  logic                   mem_read;
  logic                   mem_write;
  logic                   i_or_d;
  logic                   ir_write;
  logic                   pc_en;
  logic [1:0]             pc_source;
  logic                   reg_write;
  logic                   reg_dst;
  logic                   mem_to_reg;
  logic                   alu_src_a;
  logic [1:0]             alu_src_b;
  logic [2:0]             alu_op;
  logic                   halted;
  logic [COUNT_WIDTH-1:0] instr_count;
  logic [3:0]             state;

  modport master (
    input  opcode, funct, alu_zout, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           halted, instr_count, state
  );

  modport slave (
    output opcode, funct, alu_zout, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           halted, instr_count, state
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// R-type funct field to ALU operation decoder.
// Ports: i_funct (instruction[5:0]), o_alu_op (ALU op code),
//        o_illegal (funct is not a supported R-type operation).
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_op,
  output logic       o_illegal
);
  always_comb begin
    o_alu_op  = ALU_ADD;
    o_illegal = 1'b0;
    case (i_funct)
      FN_ADD:  o_alu_op = ALU_ADD;
      FN_SUB:  o_alu_op = ALU_SUB;
      FN_AND:  o_alu_op = ALU_AND;
      FN_OR:   o_alu_op = ALU_OR;
      FN_SLT:  o_alu_op = ALU_SLT;
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing controller: state register, retired
// instruction counter and Moore output decode.
// Ports: clk, reset (sync, active-high), bus (master modport of
// multicycle_control_if carrying opcode/funct/alu_zout/mem_ready in and all
// datapath enables/selects, halted, instr_count and state out).
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  multicycle_control_if.master bus
);
  state_t                 r_state;
  state_t                 w_next;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [2:0]             w_dec_op;
  logic                   w_dec_illegal;

  logic       w_mem_read, w_mem_write, w_i_or_d, w_ir_write, w_pc_en;
  logic [1:0] w_pc_source, w_alu_src_b;
  logic       w_reg_write, w_reg_dst, w_mem_to_reg, w_alu_src_a;
  logic [2:0] w_alu_op;

  alu_decoder u_alu_decoder (
    .i_funct   (bus.funct),
    .o_alu_op  (w_dec_op),
    .o_illegal (w_dec_illegal)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:     if (bus.mem_ready) w_next = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: w_next = MEM_ADDR;
          OP_RTYPE:     w_next = R_EXEC;
          OP_ADDI:      w_next = ADDI_EXEC;
          OP_BEQ:       w_next = BRANCH;
          OP_J:         w_next = JUMP;
          default:      w_next = HALT;
        endcase
      end
      // Only lw/sw reach MEM_ADDR, so a non-lw opcode here is sw.
      MEM_ADDR:  w_next = (bus.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (bus.mem_ready) w_next = MEM_WB;
      MEM_WB:    w_next = FETCH;
      MEM_WRITE: if (bus.mem_ready) w_next = FETCH;
      R_EXEC:    w_next = w_dec_illegal ? HALT : R_WB;
      R_WB:      w_next = FETCH;
      ADDI_EXEC: w_next = ADDI_WB;
      ADDI_WB:   w_next = FETCH;
      BRANCH:    w_next = FETCH;
      JUMP:      w_next = FETCH;
      HALT:      w_next = HALT;
      default:   w_next = HALT;
    endcase
  end

  // An instruction retires on any non-FETCH -> FETCH transition; HALT never
  // returns to FETCH except through reset, so it can never count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state != FETCH) && (w_next == FETCH))
        r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_i_or_d     = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_en      = 1'b0;
    w_pc_source  = 2'b00;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 3'b000;
    case (r_state)
      FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_alu_op    = ALU_ADD;
        w_ir_write  = bus.mem_ready;
        w_pc_en     = bus.mem_ready;
      end
      DECODE: begin
        w_alu_src_b = 2'b11;
        w_alu_op    = ALU_ADD;
      end
      MEM_ADDR, ADDI_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_op    = ALU_ADD;
      end
      MEM_READ: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
      end
      MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        w_mem_write = 1'b1;
        w_i_or_d    = 1'b1;
      end
      R_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = w_dec_op;
      end
      R_WB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      ADDI_WB:   w_reg_write = 1'b1;
      BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALU_SUB;
        w_pc_source = 2'b01;
        w_pc_en     = bus.alu_zout;
      end
      JUMP: begin
        w_pc_en     = 1'b1;
        w_pc_source = 2'b10;
      end
      default: ;
    endcase
    // Reset aborts whatever is in flight: nothing may be requested or
    // written in the reset cycle.
    if (reset) begin
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_i_or_d     = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_en      = 1'b0;
      w_pc_source  = 2'b00;
      w_reg_write  = 1'b0;
      w_reg_dst    = 1'b0;
      w_mem_to_reg = 1'b0;
      w_alu_src_a  = 1'b0;
      w_alu_src_b  = 2'b00;
      w_alu_op     = 3'b000;
    end
  end

  assign bus.mem_read    = w_mem_read;
  assign bus.mem_write   = w_mem_write;
  assign bus.i_or_d      = w_i_or_d;
  assign bus.ir_write    = w_ir_write;
  assign bus.pc_en       = w_pc_en;
  assign bus.pc_source   = w_pc_source;
  assign bus.reg_write   = w_reg_write;
  assign bus.reg_dst     = w_reg_dst;
  assign bus.mem_to_reg  = w_mem_to_reg;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.alu_op      = w_alu_op;
  assign bus.halted      = (r_state == HALT);
  assign bus.instr_count = r_count;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus
// hand-written halt/reset corner sequences.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if #(.COUNT_WIDTH(32)) bus ();

  multicycle_control #(.COUNT_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Output word field order:
  // mem_read,mem_write,i_or_d,ir_write,pc_en,pc_source[2],reg_write,reg_dst,
  // mem_to_reg,alu_src_a,alu_src_b[2],alu_op[3],halted
  localparam logic [16:0] W_Z    = 17'b0_0_0_0_0_00_0_0_0_0_00_000_0;
  localparam logic [16:0] W_FR   = 17'b1_0_0_1_1_00_0_0_0_0_01_010_0;
  localparam logic [16:0] W_FW   = 17'b1_0_0_0_0_00_0_0_0_0_01_010_0;
  localparam logic [16:0] W_DEC  = 17'b0_0_0_0_0_00_0_0_0_0_11_010_0;
  localparam logic [16:0] W_MA   = 17'b0_0_0_0_0_00_0_0_0_1_10_010_0;
  localparam logic [16:0] W_MR   = 17'b1_0_1_0_0_00_0_0_0_0_00_000_0;
  localparam logic [16:0] W_MWB  = 17'b0_0_0_0_0_00_1_0_1_0_00_000_0;
  localparam logic [16:0] W_MW   = 17'b0_1_1_0_0_00_0_0_0_0_00_000_0;
  localparam logic [16:0] W_RADD = 17'b0_0_0_0_0_00_0_0_0_1_00_010_0;
  localparam logic [16:0] W_RSUB = 17'b0_0_0_0_0_00_0_0_0_1_00_110_0;
  localparam logic [16:0] W_RAND = 17'b0_0_0_0_0_00_0_0_0_1_00_000_0;
  localparam logic [16:0] W_ROR  = 17'b0_0_0_0_0_00_0_0_0_1_00_001_0;
  localparam logic [16:0] W_RSLT = 17'b0_0_0_0_0_00_0_0_0_1_00_111_0;
  localparam logic [16:0] W_RWB  = 17'b0_0_0_0_0_00_1_1_0_0_00_000_0;
  localparam logic [16:0] W_AWB  = 17'b0_0_0_0_0_00_1_0_0_0_00_000_0;
  localparam logic [16:0] W_BT   = 17'b0_0_0_0_1_01_0_0_0_1_00_110_0;
  localparam logic [16:0] W_BN   = 17'b0_0_0_0_0_01_0_0_0_1_00_110_0;
  localparam logic [16:0] W_J    = 17'b0_0_0_0_1_10_0_0_0_0_00_000_0;
  localparam logic [16:0] W_H    = 17'b0_0_0_0_0_00_0_0_0_0_00_000_1;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic logic [16:0] ctl_word();
    return {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_en,
            bus.pc_source, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.halted};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy, input state_t st,
                     input logic [16:0] ctl, input logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
    v.st = st; v.ctl = ctl; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // One R-type instruction with zero wait states; alu_zout/mem_ready are
  // wiggled in DECODE/R_EXEC where they must have no effect.
  task automatic rtype(input logic [5:0] fn, input logic [16:0] exw, input logic [31:0] cnt);
    add(1'b0, 6'h00, fn, 1'b0, 1'b1, FETCH,  W_FR,  cnt);
    add(1'b0, 6'h00, fn, 1'b1, 1'b0, DECODE, W_DEC, cnt);
    add(1'b0, 6'h00, fn, 1'b1, 1'b1, R_EXEC, exw,   cnt);
    add(1'b0, 6'h00, fn, 1'b0, 1'b1, R_WB,   W_RWB, cnt);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.opcode = '0; bus.funct = '0; bus.alu_zout = 1'b0; bus.mem_ready = 1'b1;
    cyc();

    add(1'b1, 6'h00, 6'h00, 1'b0, 1'b1, FETCH, W_Z, 0);
    rtype(6'h20, W_RADD, 0);
    rtype(6'h22, W_RSUB, 1);
    rtype(6'h24, W_RAND, 2);
    rtype(6'h25, W_ROR,  3);
    rtype(6'h2A, W_RSLT, 4);
    // addi
    add(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, FETCH,     W_FR,  5);
    add(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, DECODE,    W_DEC, 5);
    add(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, ADDI_EXEC, W_MA,  5);
    add(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, ADDI_WB,   W_AWB, 5);
    // sw, no wait
    add(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, FETCH,     W_FR,  6);
    add(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, DECODE,    W_DEC, 6);
    add(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, MEM_ADDR,  W_MA,  6);
    add(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, MEM_WRITE, W_MW,  6);
    // beq taken then not taken
    add(1'b0, 6'h04, 6'h00, 1'b1, 1'b1, FETCH,  W_FR,  7);
    add(1'b0, 6'h04, 6'h00, 1'b1, 1'b1, DECODE, W_DEC, 7);
    add(1'b0, 6'h04, 6'h00, 1'b1, 1'b1, BRANCH, W_BT,  7);
    add(1'b0, 6'h04, 6'h00, 1'b0, 1'b1, FETCH,  W_FR,  8);
    add(1'b0, 6'h04, 6'h00, 1'b0, 1'b1, DECODE, W_DEC, 8);
    add(1'b0, 6'h04, 6'h00, 1'b0, 1'b1, BRANCH, W_BN,  8);
    // j
    add(1'b0, 6'h02, 6'h00, 1'b0, 1'b1, FETCH,  W_FR,  9);
    add(1'b0, 6'h02, 6'h00, 1'b0, 1'b1, DECODE, W_DEC, 9);
    add(1'b0, 6'h02, 6'h00, 1'b0, 1'b1, JUMP,   W_J,   9);
    // lw with 3 fetch waits and 2 read waits: 10 cycles
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, FETCH,    W_FW,  10);
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, FETCH,    W_FW,  10);
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, FETCH,    W_FW,  10);
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, FETCH,    W_FR,  10);
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, DECODE,   W_DEC, 10);
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, MEM_ADDR, W_MA,  10);
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, MEM_READ, W_MR,  10);
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, MEM_READ, W_MR,  10);
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, MEM_READ, W_MR,  10);
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, MEM_WB,   W_MWB, 10);

    foreach (vecs[i]) begin
      reset         = vecs[i].rst;
      bus.opcode    = vecs[i].op;
      bus.funct     = vecs[i].fn;
      bus.alu_zout  = vecs[i].z;
      bus.mem_ready = vecs[i].rdy;
      #1;
      chk($sformatf("row%0d_state", i), 32'(bus.state), 32'(vecs[i].st));
      chk($sformatf("row%0d_ctl", i), 32'(ctl_word()), 32'(vecs[i].ctl));
      chk($sformatf("row%0d_count", i), bus.instr_count, vecs[i].cnt);
      cyc();
    end

    // Illegal opcode: HALT after DECODE, frozen for 100 cycles.
    bus.opcode = 6'h3F; bus.mem_ready = 1'b1;
    #1;
    chk("halt_fetch_count", bus.instr_count, 32'd11);
    cyc();
    chk("halt_decode_state", 32'(bus.state), 32'(DECODE));
    cyc();
    for (int i = 0; i < 100; i++) begin
      bus.mem_ready = i[0];
      bus.alu_zout  = i[1];
      #1;
      chk($sformatf("halt%0d_state", i), 32'(bus.state), 32'(HALT));
      chk($sformatf("halt%0d_ctl", i), 32'(ctl_word()), 32'(W_H));
      chk($sformatf("halt%0d_count", i), bus.instr_count, 32'd11);
      cyc();
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0; bus.mem_ready = 1'b0; bus.alu_zout = 1'b0;
    #1;
    chk("halt_reset_state", 32'(bus.state), 32'(FETCH));
    chk("halt_reset_ctl", 32'(ctl_word()), 32'(W_FW));
    chk("halt_reset_count", bus.instr_count, 32'd0);

    // j brings the count to 1 so the aborted sw below is visible.
    bus.opcode = 6'h02; bus.mem_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("j_count", bus.instr_count, 32'd1);
    chk("j_state", 32'(bus.state), 32'(FETCH));

    // Reset during a MEM_WRITE wait.
    bus.opcode = 6'h2B; bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready = 1'b0;
    cyc(); cyc();
    chk("sw_wait_ctl", 32'(ctl_word()), 32'(W_MW));
    cyc();
    chk("sw_wait_hold_state", 32'(bus.state), 32'(MEM_WRITE));
    reset = 1'b1;
    #1;
    chk("sw_reset_ctl", 32'(ctl_word()), 32'(W_Z));
    cyc();
    reset = 1'b0;
    #1;
    chk("sw_reset_state", 32'(bus.state), 32'(FETCH));
    chk("sw_reset_count", bus.instr_count, 32'd0);

    // Unlisted R-type funct halts after R_EXEC without retiring.
    bus.opcode = 6'h00; bus.funct = 6'h3F; bus.mem_ready = 1'b1;
    cyc(); cyc();
    chk("badfn_exec_state", 32'(bus.state), 32'(R_EXEC));
    cyc();
    chk("badfn_halt_state", 32'(bus.state), 32'(HALT));
    chk("badfn_halted", 32'(bus.halted), 32'd1);
    chk("badfn_count", bus.instr_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multi-cycle MIPS datapath. It replaces the per-instruction combinational control with a state machine that drives the shared ALU, register file, instruction register, PC and unified memory over several cycles per instruction. It waits on the memory `mem_ready` handshake and counts retired instructions. It sits between the decoded instruction fields and every datapath enable and mux select in the processor top level.

## Interface
- `COUNT_WIDTH`, 32, width of retired-instruction counter
- `clk` in 1: sole clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `opcode` in 6: instruction[31:26] from the instruction register
- `funct` in 6: instruction[5:0] from the instruction register
- `alu_zout` in 1: ALU zero flag
- `mem_ready` in 1: memory completes the current read or write this cycle
- `mem_read` out 1: memory read request
- `mem_write` out 1: memory write request
- `i_or_d` out 1: address select, 0=PC, 1=ALUOut
- `ir_write` out 1: load the instruction register
- `pc_en` out 1: load the PC
- `pc_source` out 2: PC input select, 00=ALU, 01=ALUOut, 10=jump target {PC[31:28],addr26,2'b00}
- `reg_write` out 1: register file write enable
- `reg_dst` out 1: destination register select, 0=rt, 1=rd
- `mem_to_reg` out 1: write-back data select, 0=ALUOut, 1=MDR
- `alu_src_a` out 1: ALU input A select, 0=PC, 1=register A
- `alu_src_b` out 2: ALU input B select, 00=register B, 01=4, 10=sign-extended imm16, 11=sign-extended imm16<<2
- `alu_op` out 3: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- `halted` out 1: sticky illegal-instruction indication
- `instr_count` out COUNT_WIDTH: number of retired instructions
- `state` out 4: current state, for debug

## Operation
- Supported instructions:
  - R-type (opcode 0x00): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt
  - lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08
- Every output not listed for a state is 0 in that state.
- States and their outputs:
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00; ir_write=pc_en=mem_ready. If mem_ready, go to DECODE; otherwise stay.
  - DECODE: alu_src_a=0, alu_src_b=11, ADD (precomputes the branch target). Next state by opcode:
    - lw/sw → MEM_ADDR; R-type → R_EXEC; addi → ADDI_EXEC; beq → BRANCH; j → JUMP
    - any other opcode → HALT
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Go to MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ: mem_read=1, i_or_d=1. Go to MEM_WB when mem_ready.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
  - MEM_WRITE: mem_write=1, i_or_d=1. Go to FETCH when mem_ready.
  - R_EXEC: alu_src_a=1, alu_src_b=00, alu_op decoded from funct. Go to R_WB; an unlisted funct goes to HALT.
  - R_WB: reg_write=1, reg_dst=1. Go to FETCH.
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, ADD. Go to ADDI_WB.
  - ADDI_WB: reg_write=1, reg_dst=0. Go to FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01, pc_en=alu_zout. Go to FETCH.
  - JUMP: pc_en=1, pc_source=10. Go to FETCH.
  - HALT: halted=1, all enables 0. Leaves only on reset.
- `instr_count` increments by 1 on every transition from a non-FETCH state into FETCH. It wraps modulo 2^COUNT_WIDTH and never increments in HALT.

## Timing
- Reset:
  - While `reset`=1, all enables and requests are forced to 0 combinationally.
  - On the reset edge: state←FETCH, instr_count←0, halted←0.
  - The first cycle after reset is FETCH with mem_read=1.
- Reset mid-operation, including during a memory wait, aborts the instruction. No write enable is asserted in the reset cycle, and the aborted instruction is not counted.
- Output timing:
  - All outputs are Moore (decoded from the registered state).
  - Exceptions: `ir_write` and `pc_en` in FETCH are combinational on `mem_ready`; `pc_en` in BRANCH is combinational on `alu_zout`.
- Memory handshake:
  - The request is held stable until the cycle `mem_ready`=1 is sampled.
  - `mem_ready` outside FETCH/MEM_READ/MEM_WRITE is ignored.
- Latency with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles. Each memory wait cycle adds 1.

## Structure
- Package `mips_ctrl_pkg`: opcode and funct constants, alu_op encodings, and the state enum (4-bit: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP, HALT).
- Sub-module `alu_decoder`: combinational funct→{alu_op, illegal}, instantiated once for R_EXEC.
- The state register, counter and output decode live in `multicycle_control`.

## Test plan
- Reset, then add (opcode 0x00, funct 0x20) with mem_ready tied 1 → state sequence FETCH, DECODE, R_EXEC (alu_op=010), R_WB (reg_write=1, reg_dst=1), FETCH; instr_count 0→1.
- lw with mem_ready low for 3 FETCH cycles and 2 MEM_READ cycles → ir_write is a single pulse on the ready cycle; 10 cycles total; MEM_WB has reg_write=1, mem_to_reg=1.
- beq twice, alu_zout=1 then 0 → pc_en=1 with pc_source=01 in the first BRANCH, pc_en=0 in the second; both count as retired.
- j (0x02) → 3 cycles; JUMP cycle has pc_en=1, pc_source=10; instr_count increments once.
- Opcode 0x3F → HALT after DECODE; halted=1 and all enables 0 for 100 cycles; instr_count frozen; reset returns to FETCH with halted=0.
- Reset asserted during a MEM_WRITE wait → mem_write=0 in the reset cycle; next state FETCH; instr_count=0.
